operand_fetch: RTL

Decode/operand-fetch stage directly upstream of the ALU in the Tiny RISC-V datapath. Accepts one 32-bit instruction per cycle over a valid/ready handshake, decodes the supported subset (ADD, ADDI, MUL, BNE), reads a 32x32 register file with writeback bypass, and tracks outstanding destination registers with a busy-bit scoreboard. It registers ALU opcode and operands for the execute stage and owns the architectural register file written by the writeback port.

---
 rtl/operand_fetch_pkg.sv | 82 ++++++++
 rtl/operand_fetch_reg_file.sv | 44 ++++
 rtl/operand_fetch.sv | 132 +++++++++++++
 3 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch stage: ALU opcodes, RV32 encoding
// constants, field widths and the instruction decoder.
package operand_fetch_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int RIDX_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'd0,
        ALU_MUL     = 4'd1,
        ALU_BNE     = 4'd2,
        ALU_ILLEGAL = 4'd15
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Decoded control for one instruction; writes_rd ignores the rd==x0 case.
    typedef struct packed {
        alu_op_e op;
        logic    use_rs1;
        logic    use_rs2;
        logic    use_imm;
        logic    writes_rd;
        logic    branch;
        logic    illegal;
    } decode_t;

    function automatic decode_t decode_instr(input logic [XLEN-1:0] instr);
        decode_t d;
        d.op        = ALU_ILLEGAL;
        d.use_rs1   = 1'b0;
        d.use_rs2   = 1'b0;
        d.use_imm   = 1'b0;
        d.writes_rd = 1'b0;
        d.branch    = 1'b0;
        d.illegal   = 1'b1;
        case (instr[6:0])
            OPC_OP: begin
                if (instr[14:12] == F3_ADD && instr[31:25] == F7_BASE) begin
                    d.op = ALU_ADD;
                    d.illegal = 1'b0;
                end else if (instr[14:12] == F3_ADD && instr[31:25] == F7_MULDIV) begin
                    d.op = ALU_MUL;
                    d.illegal = 1'b0;
                end
                d.use_rs1   = !d.illegal;
                d.use_rs2   = !d.illegal;
                d.writes_rd = !d.illegal;
            end
            OPC_OP_IMM: begin
                if (instr[14:12] == F3_ADD) begin
                    d.op        = ALU_ADD;
                    d.illegal   = 1'b0;
                    d.use_rs1   = 1'b1;
                    d.use_imm   = 1'b1;
                    d.writes_rd = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if (instr[14:12] == F3_BNE) begin
                    d.op      = ALU_BNE;
                    d.illegal = 1'b0;
                    d.use_rs1 = 1'b1;
                    d.use_rs2 = 1'b1;
                    d.branch  = 1'b1;
                end
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/operand_fetch_reg_file.sv
// Architectural register file: 32x32, x0 hardwired to zero, two combinational
// read ports that forward a same-cycle writeback, one synchronous write port.
module operand_fetch_reg_file
    import operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [RIDX_W-1:0] i_raddr1,
    input  logic [RIDX_W-1:0] i_raddr2,
    output logic [XLEN-1:0]   o_rdata1,
    output logic [XLEN-1:0]   o_rdata2,
    input  logic              i_wen,
    input  logic [RIDX_W-1:0] i_waddr,
    input  logic [XLEN-1:0]   i_wdata
);

    logic [XLEN-1:0] r_mem [NREG];

    // Write port; reset clears every register, writes to x0 are dropped.
    // NOTE: resetting a memory array forces it into flops instead of a RAM
    // macro; it is done here because every register must read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
        end else if (i_wen && i_waddr != '0) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port 1 with x0 zeroing and writeback bypass.
    always_comb begin
        o_rdata1 = r_mem[i_raddr1];
        if (i_raddr1 == '0) o_rdata1 = '0;
        else if (i_wen && i_waddr == i_raddr1) o_rdata1 = i_wdata;
    end

    // Read port 2 with x0 zeroing and writeback bypass.
    always_comb begin
        o_rdata2 = r_mem[i_raddr2];
        if (i_raddr2 == '0) o_rdata2 = '0;
        else if (i_wen && i_waddr == i_raddr2) o_rdata2 = i_wdata;
    end

endmodule

// File: rtl/operand_fetch.sv
// Decode / operand-fetch stage: decodes ADD, ADDI, MUL, BNE, reads operands,
// stalls on busy-bit hazards and registers the ALU request for execute.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_instr,
    input  logic [XLEN-1:0]   in_pc,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [RIDX_W-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_op,
    output logic [XLEN-1:0]   out_a,
    output logic [XLEN-1:0]   out_b,
    output logic [RIDX_W-1:0] out_rd,
    output logic              out_we,
    output logic              out_branch,
    output logic [XLEN-1:0]   out_target,
    output logic              out_illegal
);

    decode_t           w_dec;
    logic [RIDX_W-1:0] w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0]   w_rdata1, w_rdata2, w_imm_i, w_imm_b, w_opnd_a, w_opnd_b;
    logic              w_we, w_hazard, w_in_ready, w_accept;
    logic [NREG-1:0]   w_busy_next;

    logic [NREG-1:0]   r_busy;
    logic              r_valid, r_we, r_branch, r_illegal;
    alu_op_e           r_op;
    logic [XLEN-1:0]   r_a, r_b, r_target;
    logic [RIDX_W-1:0] r_rd;

    assign w_dec   = decode_instr(in_instr);
    assign w_rd    = in_instr[11:7];
    assign w_rs1   = in_instr[19:15];
    assign w_rs2   = in_instr[24:20];
    assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_we    = w_dec.writes_rd && (w_rd != '0);

    operand_fetch_reg_file u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2),
        .i_wen    (wb_en),
        .i_waddr  (wb_addr),
        .i_wdata  (wb_data)
    );

    assign w_opnd_a = w_dec.use_rs1 ? w_rdata1 : '0;
    assign w_opnd_b = w_dec.use_imm ? w_imm_i : (w_dec.use_rs2 ? w_rdata2 : '0);

    // Hazard: a used source still busy after this cycle's writeback, or WAW on rd.
    // NOTE: every always_comb output gets a default before any condition so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_hazard = 1'b0;
        if (w_dec.use_rs1 && r_busy[w_rs1] && !(wb_en && wb_addr == w_rs1)) w_hazard = 1'b1;
        if (w_dec.use_rs2 && r_busy[w_rs2] && !(wb_en && wb_addr == w_rs2)) w_hazard = 1'b1;
        if (w_we && r_busy[w_rd]) w_hazard = 1'b1;
    end

    assign w_in_ready = !rst && (!r_valid || out_ready) && !w_hazard && !flush;
    assign w_accept   = in_valid && w_in_ready;
    assign in_ready   = w_in_ready;

    // Scoreboard next state: writeback and flush clear, accept sets (set wins).
    always_comb begin
        w_busy_next = r_busy;
        if (wb_en) w_busy_next[wb_addr] = 1'b0;
        if (flush && r_valid && r_we) w_busy_next[r_rd] = 1'b0;
        if (w_accept && w_we) w_busy_next[w_rd] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // values from before the edge, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_next;
    end

    // Output register toward execute: load on accept, drop on flush or consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_op      <= ALU_ADD;
            r_a       <= '0;
            r_b       <= '0;
            r_rd      <= '0;
            r_we      <= 1'b0;
            r_branch  <= 1'b0;
            r_target  <= '0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_op      <= w_dec.op;
            r_a       <= w_opnd_a;
            r_b       <= w_opnd_b;
            r_rd      <= w_dec.writes_rd ? w_rd : '0;
            r_we      <= w_we;
            r_branch  <= w_dec.branch;
            r_target  <= in_pc + w_imm_b;
            r_illegal <= w_dec.illegal;
        end else if (flush || out_ready) begin
            r_valid   <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign out_op      = r_op;
    assign out_a       = r_a;
    assign out_b       = r_b;
    assign out_rd      = r_rd;
    assign out_we      = r_we;
    assign out_branch  = r_branch;
    assign out_target  = r_target;
    assign out_illegal = r_illegal;

endmodule
